// File: rtl/tdm_demux16.sv
// rtl/tdm_demux16.sv - 16-channel TDM serial-to-parallel demultiplexer
//
// Receives one bit per qualified cycle (din_valid). The bit is steered into
// the slot given by an internal slot counter. All channels are published
// together on dout once a full frame has been collected.
//
// Optional feature: define TDM_DEMUX_PARITY_EN to append an even-parity bit
// after slot NCH-1. The parity bit is checked and the result reported on par_err.
//
// Parameters:
//   NCH         channels (slots) per frame
//   SLOT_W      slot counter width, clog2(NCH)
//   TIMEOUT     idle cycles tolerated mid-frame before abort (0 = never)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   din          serial data bit
//   din_valid    din is valid this cycle
//   frame_start  current valid bit is slot 0
//   dout         last complete frame, dout[i] = slot i
//   dout_valid   one-cycle pulse when dout updates
//   slot         slot index the next accepted bit will occupy
//   busy         frame in progress
//   sync_err     one-cycle pulse: frame_start arrived mid-frame
//   timeout_err  one-cycle pulse: mid-frame idle timeout abort
//   par_err      one-cycle pulse: parity mismatch (0 without parity)

module tdm_demux16 #(
  parameter int NCH     = 16,
  parameter int SLOT_W  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              din_valid,
  input  logic              frame_start,
  output logic [NCH-1:0]    dout,
  output logic              dout_valid,
  output logic [SLOT_W-1:0] slot,
  output logic              busy,
  output logic              sync_err,
  output logic              timeout_err,
  output logic              par_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RECV   = 2'd1;
`ifdef TDM_DEMUX_PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd2;
`endif

  // The idle counter only has to reach TIMEOUT-1. When TIMEOUT is small or
  // disabled, keep at least one bit so that the declarations stay legal.
  localparam int               CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] IDLE_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam bit               TO_EN     = (TIMEOUT > 0);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NCH - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

  logic [1:0]        state;
  logic [SLOT_W-1:0] slot_q;
  logic [NCH-1:0]    shadow;
  logic [CNT_W-1:0]  idle_cnt;
  logic [NCH-1:0]    dout_q;
  logic              dout_valid_q;
  logic              sync_err_q;
  logic              timeout_err_q;

  // Frame as it will look once the current bit lands in the last slot. This
  // lets the frame publish on the same edge that accepts the final bit.
  logic [NCH-1:0]    frame_word;
  // The idle cycle being accepted now is the one that exhausts the budget.
  logic              idle_expire;

  always_comb begin
    frame_word          = shadow;
    frame_word[NCH-1]   = din;
  end

  assign idle_expire = TO_EN && (idle_cnt == IDLE_LAST);

`ifdef TDM_DEMUX_PARITY_EN
  logic par_err_q;
  // Even parity: the data bits XORed with the parity bit must be 0.
  logic par_bad;
  assign par_bad = (^shadow) ^ din;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      slot_q        <= '0;
      shadow        <= '0;
      idle_cnt      <= '0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      sync_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_err_q     <= 1'b0;
`endif
    end else begin
      // All status outputs are single-cycle pulses.
      dout_valid_q  <= 1'b0;
      sync_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_err_q     <= 1'b0;
`endif

      case (state)
        ST_IDLE: begin
          idle_cnt <= '0;
          // Valid bits without frame_start are line noise between frames.
          if (din_valid && frame_start) begin
            shadow[0] <= din;
            slot_q    <= SLOT_ONE;
            state     <= ST_RECV;
          end
        end

        ST_RECV: begin
          if (din_valid) begin
            idle_cnt <= '0;
            if (frame_start) begin
              // Resync: the new bit becomes slot 0 of a fresh frame. The
              // stale shadow bits are overwritten before they can publish.
              sync_err_q <= 1'b1;
              shadow[0]  <= din;
              slot_q     <= SLOT_ONE;
            end else if (slot_q == SLOT_LAST) begin
`ifdef TDM_DEMUX_PARITY_EN
              shadow[NCH-1] <= din;
              slot_q        <= '0;
              state         <= ST_PARITY;
`else
              dout_q       <= frame_word;
              dout_valid_q <= 1'b1;
              slot_q       <= '0;
              state        <= ST_IDLE;
`endif
            end else begin
              shadow[slot_q] <= din;
              slot_q         <= slot_q + SLOT_ONE;
            end
          end else if (TO_EN) begin
            if (idle_expire) begin
              timeout_err_q <= 1'b1;
              idle_cnt      <= '0;
              slot_q        <= '0;
              state         <= ST_IDLE;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end

`ifdef TDM_DEMUX_PARITY_EN
        ST_PARITY: begin
          if (din_valid) begin
            idle_cnt <= '0;
            if (frame_start) begin
              sync_err_q <= 1'b1;
              shadow[0]  <= din;
              slot_q     <= SLOT_ONE;
              state      <= ST_RECV;
            end else begin
              // Publish even if the parity check fails. The consumer decides
              // what to do with a frame that is flagged bad.
              dout_q       <= shadow;
              dout_valid_q <= 1'b1;
              par_err_q    <= par_bad;
              state        <= ST_IDLE;
            end
          end else if (TO_EN) begin
            if (idle_expire) begin
              timeout_err_q <= 1'b1;
              idle_cnt      <= '0;
              state         <= ST_IDLE;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
`endif

        default: begin
          state  <= ST_IDLE;
          slot_q <= '0;
        end
      endcase
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign slot        = slot_q;
  assign busy        = (state != ST_IDLE);
  assign sync_err    = sync_err_q;
  assign timeout_err = timeout_err_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign par_err     = par_err_q;
`else
  assign par_err     = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux16.sv
// tb/tb_tdm_demux16.sv - directed self-checking bench for tdm_demux16

module tb_tdm_demux16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic [3:0]  slot;
  logic        busy;
  logic        sync_err;
  logic        timeout_err;
  logic        par_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  tdm_demux16 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .slot        (slot),
    .busy        (busy),
    .sync_err    (sync_err),
    .timeout_err (timeout_err),
    .par_err     (par_err)
  );

  always #5 clk = ~clk;

  // Present one cycle of inputs, then land 1 time unit after the edge.
  task automatic drive(input logic v, input logic d, input logic fs);
    din_valid   = v;
    din         = d;
    frame_start = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] w, input int first, input int last,
                           input logic fs_first);
    for (int i = first; i <= last; i++)
      drive(1'b1, w[i], (i == first) && fs_first);
  endtask

  task automatic send_frame(input logic [15:0] w);
    send_bits(w, 0, 15, 1'b1);
`ifdef TDM_DEMUX_PARITY_EN
    drive(1'b1, ^w, 1'b0);
`endif
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    total_cnt++; if (dout !== 16'h0000) $display("FAIL reset_dout got=%h exp=0000", dout); else pass_cnt++;
    total_cnt++; if (slot !== 4'd0) $display("FAIL reset_slot got=%0d exp=0", slot); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    total_cnt++; if ({dout_valid, sync_err, timeout_err, par_err} !== 4'b0000)
      $display("FAIL reset_pulses got=%b exp=0000", {dout_valid, sync_err, timeout_err, par_err}); else pass_cnt++;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic;
    int early_valid = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 16'h5A5A >> i, i == 0);
      if (i < 15 && dout_valid !== 1'b0) early_valid++;
    end
`ifdef TDM_DEMUX_PARITY_EN
    total_cnt++; if (dout_valid !== 1'b0) $display("FAIL basic_par_wait_valid got=%b exp=0", dout_valid); else pass_cnt++;
    total_cnt++; if (slot !== 4'd0 || busy !== 1'b1)
      $display("FAIL basic_par_state got slot=%0d busy=%b exp slot=0 busy=1", slot, busy); else pass_cnt++;
    drive(1'b1, 1'b0, 1'b0);
`endif
    total_cnt++; if (early_valid != 0) $display("FAIL basic_early_valid got=%0d exp=0", early_valid); else pass_cnt++;
    total_cnt++; if (dout !== 16'h5A5A) $display("FAIL basic_dout got=%h exp=5a5a", dout); else pass_cnt++;
    total_cnt++; if (dout_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", dout_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy got=%b exp=0", busy); else pass_cnt++;
    total_cnt++; if (par_err !== 1'b0) $display("FAIL basic_par_err got=%b exp=0", par_err); else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0);
    total_cnt++; if (dout_valid !== 1'b0) $display("FAIL basic_valid_pulse got=%b exp=0", dout_valid); else pass_cnt++;
    total_cnt++; if (dout !== 16'h5A5A) $display("FAIL basic_dout_hold got=%h exp=5a5a", dout); else pass_cnt++;
  endtask

  task automatic test_resync;
    send_bits(16'h0000, 0, 8, 1'b1);
    total_cnt++; if (slot !== 4'd9) $display("FAIL resync_pre_slot got=%0d exp=9", slot); else pass_cnt++;
    drive(1'b1, 1'b1, 1'b1);
    total_cnt++; if (sync_err !== 1'b1) $display("FAIL resync_sync_err got=%b exp=1", sync_err); else pass_cnt++;
    total_cnt++; if (slot !== 4'd1 || busy !== 1'b1)
      $display("FAIL resync_state got slot=%0d busy=%b exp slot=1 busy=1", slot, busy); else pass_cnt++;
    total_cnt++; if (dout !== 16'h5A5A || dout_valid !== 1'b0)
      $display("FAIL resync_dout_kept got=%h/%b exp=5a5a/0", dout, dout_valid); else pass_cnt++;
    send_bits(16'hFFFF, 1, 1, 1'b0);
    total_cnt++; if (sync_err !== 1'b0) $display("FAIL resync_single_pulse got=%b exp=0", sync_err); else pass_cnt++;
    send_bits(16'hFFFF, 2, 14, 1'b0);
    total_cnt++; if (dout !== 16'h5A5A) $display("FAIL resync_dout_mid got=%h exp=5a5a", dout); else pass_cnt++;
    send_bits(16'hFFFF, 15, 15, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
    drive(1'b1, 1'b0, 1'b0);
`endif
    total_cnt++; if (dout !== 16'hFFFF || dout_valid !== 1'b1)
      $display("FAIL resync_new_frame got=%h/%b exp=ffff/1", dout, dout_valid); else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_gapped;
    int bad_slot = 0;
    int bad_to = 0;
    send_bits(16'h5A5A, 0, 7, 1'b1);
    for (int g = 0; g < 5; g++) begin
      drive(1'b0, 1'b1, 1'b0);
      if (slot !== 4'd8) bad_slot++;
      if (timeout_err !== 1'b0) bad_to++;
    end
    total_cnt++; if (bad_slot != 0) $display("FAIL gap_slot_hold got=%0d bad cycles exp=0", bad_slot); else pass_cnt++;
    total_cnt++; if (bad_to != 0) $display("FAIL gap_timeout got=%0d bad cycles exp=0", bad_to); else pass_cnt++;
    send_bits(16'h5A5A, 8, 15, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
    drive(1'b1, 1'b0, 1'b0);
`endif
    total_cnt++; if (dout !== 16'h5A5A || dout_valid !== 1'b1)
      $display("FAIL gap_dout got=%h/%b exp=5a5a/1", dout, dout_valid); else pass_cnt++;
    total_cnt++; if (timeout_err !== 1'b0) $display("FAIL gap_timeout_end got=%b exp=0", timeout_err); else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    int early = 0;
    send_bits(16'hFFFF, 0, 3, 1'b1);
    for (int k = 1; k <= 63; k++) begin
      drive(1'b0, 1'b0, 1'b0);
      if (timeout_err !== 1'b0 || busy !== 1'b1) early++;
    end
    total_cnt++; if (early != 0) $display("FAIL to_early got=%0d bad cycles exp=0", early); else pass_cnt++;
    total_cnt++; if (slot !== 4'd4) $display("FAIL to_slot_hold got=%0d exp=4", slot); else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0);
    total_cnt++; if (timeout_err !== 1'b1) $display("FAIL to_pulse got=%b exp=1", timeout_err); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0 || slot !== 4'd0)
      $display("FAIL to_state got busy=%b slot=%0d exp busy=0 slot=0", busy, slot); else pass_cnt++;
    total_cnt++; if (dout !== 16'h5A5A || dout_valid !== 1'b0)
      $display("FAIL to_dout got=%h/%b exp=5a5a/0", dout, dout_valid); else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0);
    total_cnt++; if (timeout_err !== 1'b0) $display("FAIL to_single_pulse got=%b exp=0", timeout_err); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    send_bits(16'hFFFF, 0, 5, 1'b1);
    total_cnt++; if (slot !== 4'd6) $display("FAIL rmid_pre_slot got=%0d exp=6", slot); else pass_cnt++;
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    total_cnt++; if (dout !== 16'h0000 || slot !== 4'd0 || busy !== 1'b0)
      $display("FAIL rmid_state got dout=%h slot=%0d busy=%b exp 0000/0/0", dout, slot, busy); else pass_cnt++;
    send_frame(16'h1234);
    total_cnt++; if (dout !== 16'h1234 || dout_valid !== 1'b1)
      $display("FAIL rmid_next_frame got=%h/%b exp=1234/1", dout, dout_valid); else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 1'b1, 1'b0);
    total_cnt++; if (busy !== 1'b0 || slot !== 4'd0 || sync_err !== 1'b0)
      $display("FAIL idle_noise got busy=%b slot=%0d sync=%b exp 0/0/0", busy, slot, sync_err); else pass_cnt++;
    send_frame(16'hC3A5);
    total_cnt++; if (dout !== 16'hC3A5 || dout_valid !== 1'b1)
      $display("FAIL b2b_first got=%h/%b exp=c3a5/1", dout, dout_valid); else pass_cnt++;
    send_frame(16'h0F0F);
    total_cnt++; if (dout !== 16'h0F0F || dout_valid !== 1'b1)
      $display("FAIL b2b_second got=%h/%b exp=0f0f/1", dout, dout_valid); else pass_cnt++;
    total_cnt++; if (sync_err !== 1'b0) $display("FAIL b2b_sync_err got=%b exp=0", sync_err); else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0);
    total_cnt++; if (dout_valid !== 1'b0) $display("FAIL b2b_valid_drop got=%b exp=0", dout_valid); else pass_cnt++;
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  task automatic test_parity;
    send_bits(16'h5A5A, 0, 15, 1'b1);
    total_cnt++; if (dout_valid !== 1'b0 || dout !== 16'h0F0F)
      $display("FAIL par_wait got=%h/%b exp=0f0f/0", dout, dout_valid); else pass_cnt++;
    drive(1'b1, 1'b0, 1'b0);
    total_cnt++; if (dout !== 16'h5A5A || dout_valid !== 1'b1 || par_err !== 1'b0)
      $display("FAIL par_good got=%h/%b/%b exp=5a5a/1/0", dout, dout_valid, par_err); else pass_cnt++;
    send_bits(16'hFFFF, 0, 15, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    total_cnt++; if (dout !== 16'hFFFF || dout_valid !== 1'b1 || par_err !== 1'b1)
      $display("FAIL par_bad got=%h/%b/%b exp=ffff/1/1", dout, dout_valid, par_err); else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0);
    total_cnt++; if (par_err !== 1'b0) $display("FAIL par_single_pulse got=%b exp=0", par_err); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_resync();
    test_gapped();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
`ifdef TDM_DEMUX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
